spmv_mem_arbiter: RTL and testbench



---
 rtl/spmv_pkg.sv | 16 +
 rtl/spmv_mem_arbiter_if.sv | 28 ++
 rtl/spmv_req_fifo.sv | 60 ++++++
 rtl/spmv_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_spmv_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmv_pkg.sv
// Shared constants and tag-layout helpers for the SpMV memory arbiter.
package spmv_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  // Response tag carries {utag, channel}.
  function automatic int unsigned tag_width(input int unsigned num_ch, input int unsigned utag_w);
    return utag_w + ch_width(num_ch);
  endfunction

endpackage

// File: rtl/spmv_mem_arbiter_if.sv
// Memory-side request/response bus of the SpMV arbiter.
interface spmv_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 4
) ();

  logic              mem_req_ld;
  logic              mem_req_st;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_d_or_tag;
  logic              mem_req_stall;
  logic              mem_rsp_push;
  logic [TAG_W-1:0]  mem_rsp_tag;
  logic [DATA_W-1:0] mem_rsp_q;
  logic              mem_rsp_stall;

  modport master (
    output mem_req_ld, mem_req_st, mem_req_addr, mem_req_d_or_tag, mem_rsp_stall,
    input  mem_req_stall, mem_rsp_push, mem_rsp_tag, mem_rsp_q
  );

  modport slave (
    input  mem_req_ld, mem_req_st, mem_req_addr, mem_req_d_or_tag, mem_rsp_stall,
    output mem_req_stall, mem_rsp_push, mem_rsp_tag, mem_rsp_q
  );

endinterface

// File: rtl/spmv_req_fifo.sv
// Per-channel request FIFO with first-word fall-through head and almost-full flag.
module spmv_req_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_COUNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             almost_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d, free;
  logic             full, wr_en, rd_en;

  // Fullness is judged on the registered count, so a push to a full FIFO is
  // dropped even if the same cycle pops.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign free        = CNT_W'(DEPTH) - count_q;
  assign almost_full = (free <= CNT_W'(AF_COUNT));
  assign wr_en       = push & ~full;
  assign rd_en       = pop & ~empty;
  assign rdata       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// Multi-channel load/store arbiter onto one memory port, with load accounting
// and response routing back to the issuing channel.
module spmv_mem_arbiter
  import spmv_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_W     = 48,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned UTAG_W     = 2,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned AF_COUNT   = 8,
  parameter int unsigned ARB_MODE   = ARB_FIXED,
  parameter int unsigned MAX_OUT    = 64,
  localparam int unsigned CH_W      = ch_width(NUM_CH),
  localparam int unsigned TAG_W     = tag_width(NUM_CH, UTAG_W),
  localparam int unsigned OUT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_push,
  input  logic [NUM_CH-1:0]        ch_st,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*UTAG_W-1:0] ch_utag,
  output logic [NUM_CH-1:0]        ch_almost_full,
  spmv_mem_arbiter_if.master       mem,
  output logic [NUM_CH-1:0]        rsp_ch_push,
  output logic [UTAG_W-1:0]        rsp_utag,
  output logic [DATA_W-1:0]        rsp_q,
  input  logic [NUM_CH-1:0]        ch_rsp_stall,
  output logic [OUT_W-1:0]         outstanding,
  output logic                     idle,
  output logic                     tag_err
);

  localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W + UTAG_W;

  logic [NUM_CH-1:0] empty, pop, head_st;
  logic [ADDR_W-1:0] head_addr [NUM_CH];
  logic [DATA_W-1:0] head_data [NUM_CH];
  logic [UTAG_W-1:0] head_utag [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ENT_W-1:0] ent;

    spmv_req_fifo #(
      .WIDTH   (ENT_W),
      .DEPTH   (FIFO_DEPTH),
      .AF_COUNT(AF_COUNT)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (ch_push[i]),
      .wdata      ({ch_st[i], ch_addr[i*ADDR_W +: ADDR_W], ch_data[i*DATA_W +: DATA_W],
                    ch_utag[i*UTAG_W +: UTAG_W]}),
      .pop        (pop[i]),
      .rdata      (ent),
      .empty      (empty[i]),
      .almost_full(ch_almost_full[i])
    );

    assign {head_st[i], head_addr[i], head_data[i], head_utag[i]} = ent;
  end

  logic              out_full, can_grant, grant_vld, sel_st, ld_issue;
  logic [CH_W-1:0]   grant_ch, last_grant_q, rsp_ch;
  logic [ADDR_W-1:0] sel_addr, req_addr_q;
  logic [DATA_W-1:0] sel_data, req_dq_q, rsp_q_q;
  logic [UTAG_W-1:0] sel_utag, rsp_utag_q;
  logic              req_ld_q, req_st_q, rsp_stall_q, tag_err_q, tag_err_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [NUM_CH-1:0] rsp_push_q, rsp_push_d;
  int                idx;

  assign out_full  = (outstanding_q == OUT_W'(MAX_OUT));
  assign can_grant = en & ~mem.mem_req_stall;

  // Search order: fixed from ch0, or rotating from the channel after the last winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    sel_st    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_utag  = '0;
    idx       = 0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      idx = (ARB_MODE == ARB_RR) ? ((int'(last_grant_q) + 1 + k) % int'(NUM_CH)) : k;
      if (can_grant && !grant_vld && !empty[idx] && (head_st[idx] || !out_full)) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
        sel_st    = head_st[idx];
        sel_addr  = head_addr[idx];
        sel_data  = head_data[idx];
        sel_utag  = head_utag[idx];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pop[i] = grant_vld && (grant_ch == CH_W'(i));
    end
  end

  assign ld_issue = grant_vld & ~sel_st;
  assign rsp_ch   = mem.mem_rsp_tag[CH_W-1:0];

  always_comb begin
    outstanding_d = outstanding_q;
    tag_err_d     = tag_err_q;
    rsp_push_d    = '0;
    case ({ld_issue, mem.mem_rsp_push})
      2'b10: outstanding_d = outstanding_q + OUT_W'(1);
      2'b01: begin
        if (outstanding_q == '0) tag_err_d = 1'b1;
        else                     outstanding_d = outstanding_q - OUT_W'(1);
      end
      default: ;
    endcase
    for (int i = 0; i < int'(NUM_CH); i++) begin
      rsp_push_d[i] = mem.mem_rsp_push && (rsp_ch == CH_W'(i));
    end
    // A response naming a channel that does not exist is routed nowhere.
    if (mem.mem_rsp_push && (rsp_push_d == '0)) tag_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ld_q      <= 1'b0;
      req_st_q      <= 1'b0;
      req_addr_q    <= '0;
      req_dq_q      <= '0;
      last_grant_q  <= CH_W'(NUM_CH - 1);
      outstanding_q <= '0;
      tag_err_q     <= 1'b0;
      rsp_push_q    <= '0;
      rsp_utag_q    <= '0;
      rsp_q_q       <= '0;
      rsp_stall_q   <= 1'b0;
    end else begin
      req_ld_q      <= ld_issue;
      req_st_q      <= grant_vld & sel_st;
      if (grant_vld) begin
        req_addr_q   <= sel_addr;
        req_dq_q     <= sel_st ? sel_data : DATA_W'({sel_utag, grant_ch});
        last_grant_q <= grant_ch;
      end
      outstanding_q <= outstanding_d;
      tag_err_q     <= tag_err_d;
      rsp_push_q    <= rsp_push_d;
      if (mem.mem_rsp_push) begin
        rsp_utag_q <= mem.mem_rsp_tag[TAG_W-1:CH_W];
        rsp_q_q    <= mem.mem_rsp_q;
      end
      rsp_stall_q   <= |ch_rsp_stall;
    end
  end

  assign mem.mem_req_ld       = req_ld_q;
  assign mem.mem_req_st       = req_st_q;
  assign mem.mem_req_addr     = req_addr_q;
  assign mem.mem_req_d_or_tag = req_dq_q;
  assign mem.mem_rsp_stall    = rsp_stall_q;
  assign rsp_ch_push          = rsp_push_q;
  assign rsp_utag             = rsp_utag_q;
  assign rsp_q                = rsp_q_q;
  assign outstanding          = outstanding_q;
  assign tag_err              = tag_err_q;
  assign idle                 = (&empty) && (outstanding_q == '0) && !req_ld_q && !req_st_q;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Scoreboard bench: fixed-priority and round-robin arbiters share one stimulus stream.
module tb_spmv_mem_arbiter;
  import spmv_pkg::*;

  localparam int unsigned NCH = 3, AW = 16, DW = 32, UW = 2, DEPTH = 8, AFC = 2, MAXO = 4;
  localparam int unsigned TW = 4, OW = 3;

  typedef struct packed {
    logic st; logic [AW-1:0] addr; logic [DW-1:0] data; logic [UW-1:0] utag;
  } ent_t;
  typedef struct packed {
    logic ld; logic st; logic [AW-1:0] addr; logic [DW-1:0] dq; logic [NCH-1:0] rpush;
    logic rstall; logic [OW-1:0] outs; logic idle; logic err; logic [NCH-1:0] af;
  } stat_t;
  typedef struct packed { logic st; logic [AW-1:0] addr; logic [DW-1:0] dq; } req_t;
  typedef struct packed { logic [UW-1:0] utag; logic [DW-1:0] q; } rsp_t;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mem_req_stall = 1'b0;
  logic [NCH-1:0] ch_push = '0, ch_st = '0, ch_rsp_stall = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH*UW-1:0] ch_utag = '0;
  logic rsp_push_v [2];
  logic [TW-1:0] rsp_tag_v [2];
  logic [DW-1:0] rsp_q_v [2];

  logic [NCH-1:0] af [2], rpush [2];
  logic [UW-1:0] rutag [2];
  logic [DW-1:0] rq [2], d_dq [2];
  logic [OW-1:0] outs [2];
  logic idle_o [2], err_o [2], d_ld [2], d_st [2], d_rstall [2];
  logic [AW-1:0] d_addr [2];

  int n_checks = 0, n_pass = 0;
  logic mon_on = 1'b0, auto_rsp = 1'b0;

  always #5 clk = ~clk;

  spmv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) if_fp ();
  spmv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) if_rr ();

  assign if_fp.mem_req_stall = mem_req_stall;
  assign if_fp.mem_rsp_push  = rsp_push_v[0];
  assign if_fp.mem_rsp_tag   = rsp_tag_v[0];
  assign if_fp.mem_rsp_q     = rsp_q_v[0];
  assign if_rr.mem_req_stall = mem_req_stall;
  assign if_rr.mem_rsp_push  = rsp_push_v[1];
  assign if_rr.mem_rsp_tag   = rsp_tag_v[1];
  assign if_rr.mem_rsp_q     = rsp_q_v[1];
  assign d_ld[0] = if_fp.mem_req_ld;        assign d_ld[1] = if_rr.mem_req_ld;
  assign d_st[0] = if_fp.mem_req_st;        assign d_st[1] = if_rr.mem_req_st;
  assign d_addr[0] = if_fp.mem_req_addr;    assign d_addr[1] = if_rr.mem_req_addr;
  assign d_dq[0] = if_fp.mem_req_d_or_tag;  assign d_dq[1] = if_rr.mem_req_d_or_tag;
  assign d_rstall[0] = if_fp.mem_rsp_stall; assign d_rstall[1] = if_rr.mem_rsp_stall;

  spmv_mem_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .UTAG_W(UW), .FIFO_DEPTH(DEPTH),
    .AF_COUNT(AFC), .ARB_MODE(ARB_FIXED), .MAX_OUT(MAXO)
  ) u_fp (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_push(ch_push), .ch_st(ch_st), .ch_addr(ch_addr),
    .ch_data(ch_data), .ch_utag(ch_utag), .ch_almost_full(af[0]), .mem(if_fp),
    .rsp_ch_push(rpush[0]), .rsp_utag(rutag[0]), .rsp_q(rq[0]), .ch_rsp_stall(ch_rsp_stall),
    .outstanding(outs[0]), .idle(idle_o[0]), .tag_err(err_o[0])
  );

  spmv_mem_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .UTAG_W(UW), .FIFO_DEPTH(DEPTH),
    .AF_COUNT(AFC), .ARB_MODE(ARB_RR), .MAX_OUT(MAXO)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_push(ch_push), .ch_st(ch_st), .ch_addr(ch_addr),
    .ch_data(ch_data), .ch_utag(ch_utag), .ch_almost_full(af[1]), .mem(if_rr),
    .rsp_ch_push(rpush[1]), .rsp_utag(rutag[1]), .rsp_q(rq[1]), .ch_rsp_stall(ch_rsp_stall),
    .outstanding(outs[1]), .idle(idle_o[1]), .tag_err(err_o[1])
  );

  // Reference model: per-channel arrays as queues, model 0 fixed priority, model 1 rotating.
  ent_t mf [2][NCH][DEPTH];
  int mcnt [2][NCH];
  int mout [2], mlast [2];
  logic merr [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mdq [2];
  stat_t exp_stat [2][$];
  req_t exp_req [2][$];
  rsp_t exp_rsp [2][$];
  logic [TW-1:0] pend [2][$];

  task automatic check(input string name, input int m, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d got=%h exp=%h", name, m, got, exp);
  endtask

  task automatic model_step(input int m);
    stat_t s;
    ent_t e;
    int win, c;
    logic inc, dec;
    logic full_pre [NCH];
    logic [1:0] wch;
    s = '0;
    if (!rst_n) begin
      for (int i = 0; i < int'(NCH); i++) mcnt[m][i] = 0;
      mout[m] = 0; mlast[m] = NCH - 1; merr[m] = 1'b0; maddr[m] = '0; mdq[m] = '0;
      pend[m].delete();
      s.idle = 1'b1;
      exp_stat[m].push_back(s);
      return;
    end
    for (int i = 0; i < int'(NCH); i++) full_pre[i] = (mcnt[m][i] == int'(DEPTH));
    win = -1;
    if (en && !mem_req_stall) begin
      for (int k = 0; k < int'(NCH); k++) begin
        c = (m == 1) ? (mlast[m] + 1 + k) % NCH : k;
        if (win < 0 && mcnt[m][c] > 0 && (mf[m][c][0].st || mout[m] < int'(MAXO))) win = c;
      end
    end
    inc = 1'b0;
    if (win >= 0) begin
      e = mf[m][win][0];
      for (int j = 0; j < int'(DEPTH) - 1; j++) mf[m][win][j] = mf[m][win][j+1];
      mcnt[m][win]--;
      mlast[m] = win;
      wch = 2'(win);
      s.ld = !e.st;
      s.st = e.st;
      maddr[m] = e.addr;
      mdq[m] = e.st ? e.data : DW'({e.utag, wch});
      exp_req[m].push_back('{st: e.st, addr: e.addr, dq: mdq[m]});
      if (!e.st) begin
        inc = 1'b1;
        pend[m].push_back({e.utag, wch});
      end
    end
    dec = rsp_push_v[m];
    if (inc && !dec) mout[m]++;
    else if (dec && !inc) begin
      if (mout[m] == 0) merr[m] = 1'b1;
      else mout[m]--;
    end
    if (dec) begin
      wch = rsp_tag_v[m][1:0];
      if (int'(wch) < int'(NCH)) begin
        s.rpush = NCH'(1) << wch;
        exp_rsp[m].push_back('{utag: rsp_tag_v[m][3:2], q: rsp_q_v[m]});
      end else merr[m] = 1'b1;
    end
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_push[i] && !full_pre[i]) begin
        mf[m][i][mcnt[m][i]] = '{st: ch_st[i], addr: ch_addr[i*AW +: AW],
                                 data: ch_data[i*DW +: DW], utag: ch_utag[i*UW +: UW]};
        mcnt[m][i]++;
      end
      s.af[i] = (int'(DEPTH) - mcnt[m][i]) <= int'(AFC);
    end
    s.rstall = |ch_rsp_stall;
    s.addr = maddr[m];
    s.dq = mdq[m];
    s.outs = OW'(mout[m]);
    s.err = merr[m];
    s.idle = (mcnt[m][0] == 0) && (mcnt[m][1] == 0) && (mcnt[m][2] == 0) && (mout[m] == 0)
             && !s.ld && !s.st;
    exp_stat[m].push_back(s);
  endtask

  function automatic stat_t get_stat(input int m);
    stat_t s;
    s.ld = d_ld[m]; s.st = d_st[m]; s.addr = d_addr[m]; s.dq = d_dq[m]; s.rpush = rpush[m];
    s.rstall = d_rstall[m]; s.outs = outs[m]; s.idle = idle_o[m]; s.err = err_o[m];
    s.af = af[m];
    return s;
  endfunction

  // Called at a negedge with this cycle's inputs set; returns at the next negedge.
  task automatic step();
    for (int m = 0; m < 2; m++) begin
      if (!rsp_push_v[m] && auto_rsp && rst_n && pend[m].size() > 0 &&
          $urandom_range(0, 2) == 0) begin
        rsp_push_v[m] = 1'b1;
        rsp_tag_v[m] = pend[m].pop_front();
        rsp_q_v[m] = $urandom;
      end
    end
    model_step(0);
    model_step(1);
    @(negedge clk);
    ch_push = '0;
    for (int m = 0; m < 2; m++) rsp_push_v[m] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_ch(input int c, input logic st, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [UW-1:0] u);
    ch_push[c] = 1'b1;
    ch_st[c] = st;
    ch_addr[c*AW +: AW] = a;
    ch_data[c*DW +: DW] = d;
    ch_utag[c*UW +: UW] = u;
  endtask

  task automatic send_rsp(input logic [TW-1:0] tag);
    for (int m = 0; m < 2; m++) begin
      rsp_push_v[m] = 1'b1;
      rsp_tag_v[m] = tag;
      rsp_q_v[m] = $urandom;
    end
  endtask

  task automatic pulse_reset();
    stat_t r;
    rst_n = 1'b0;
    #1;
    r = '0;
    r.idle = 1'b1;
    for (int m = 0; m < 2; m++) check("reset_now", m, 64'(get_stat(m)), 64'(r));
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  initial begin
    stat_t s, g;
    req_t rqe;
    rsp_t rse;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        for (int m = 0; m < 2; m++) begin
          g = get_stat(m);
          if (exp_stat[m].size() == 0) check("stat_underflow", m, 64'(1), 64'(0));
          else begin
            s = exp_stat[m].pop_front();
            check("status", m, 64'(g), 64'(s));
          end
          if (g.ld || g.st) begin
            if (exp_req[m].size() == 0) check("req_unexpected", m, 64'(1), 64'(0));
            else begin
              rqe = exp_req[m].pop_front();
              check("mem_req", m, 64'({g.st, g.addr, g.dq}), 64'(rqe));
            end
          end
          if (g.rpush != '0) begin
            if (exp_rsp[m].size() == 0) check("rsp_unexpected", m, 64'(1), 64'(0));
            else begin
              rse = exp_rsp[m].pop_front();
              check("rsp_route", m, 64'({rutag[m], rq[m]}), 64'(rse));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      rsp_push_v[m] = 1'b0; rsp_tag_v[m] = '0; rsp_q_v[m] = '0;
    end
    @(negedge clk);
    mon_on = 1'b1;
    steps(2);
    rst_n = 1'b1;
    en = 1'b1;
    steps(2);

    // Two loads each on ch0 and ch2 in the same cycles.
    set_ch(0, 1'b0, 16'h1000, 32'h0, 2'd0); set_ch(2, 1'b0, 16'h2000, 32'h0, 2'd0); step();
    set_ch(0, 1'b0, 16'h1001, 32'h0, 2'd0); set_ch(2, 1'b0, 16'h2001, 32'h0, 2'd0); step();
    steps(6);
    auto_rsp = 1'b1;
    steps(15);

    // Six loads on ch1 plus a store on ch0 against the outstanding limit.
    auto_rsp = 1'b0;
    en = 1'b0;
    set_ch(0, 1'b1, 16'h3000, 32'hCAFE0000, 2'd1);
    set_ch(1, 1'b0, 16'h4000, 32'h0, 2'd2); step();
    for (int i = 1; i < 6; i++) begin
      set_ch(1, 1'b0, 16'h4000 + 16'(i), 32'h0, 2'(i)); step();
    end
    en = 1'b1;
    steps(8);
    auto_rsp = 1'b1;
    steps(20);

    // Response routing: bad channel index while loads are in flight, then a valid tag.
    auto_rsp = 1'b0;
    set_ch(1, 1'b0, 16'h5000, 32'h0, 2'd3); step();
    set_ch(1, 1'b0, 16'h5001, 32'h0, 2'd3); step();
    steps(3);
    send_rsp(4'h3); step();
    send_rsp(4'hD); step();
    steps(2);
    pulse_reset();
    steps(2);

    // Memory stall with three queued requests.
    en = 1'b1;
    mem_req_stall = 1'b1;
    set_ch(2, 1'b1, 16'h6002, 32'h22222222, 2'd0);
    set_ch(0, 1'b0, 16'h6000, 32'h0, 2'd1);
    set_ch(1, 1'b1, 16'h6001, 32'h11111111, 2'd0); step();
    steps(9);
    mem_req_stall = 1'b0;
    auto_rsp = 1'b1;
    steps(12);

    // All channels pushing stores continuously, filling FIFOs past almost-full.
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < int'(NCH); c++) set_ch(c, 1'b1, 16'(c * 256 + i), $urandom, 2'd0);
      step();
    end
    steps(30);

    // Randomized traffic with a reset pulse mid-burst.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      mem_req_stall = ($urandom_range(0, 4) == 0);
      ch_rsp_stall = NCH'($urandom);
      for (int c = 0; c < int'(NCH); c++) begin
        if ($urandom_range(0, 9) < 4)
          set_ch(c, 1'($urandom), 16'($urandom), $urandom, 2'($urandom));
      end
      if (i == 200) begin
        ch_push = '0;
        pulse_reset();
        send_rsp(4'h1);
      end
      step();
    end

    en = 1'b1;
    mem_req_stall = 1'b0;
    ch_rsp_stall = '0;
    steps(80);
    mon_on = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check("stat_left", m, 64'(exp_stat[m].size()), 64'(0));
      check("req_left", m, 64'(exp_req[m].size()), 64'(0));
      check("rsp_left", m, 64'(exp_rsp[m].size()), 64'(0));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
